// File: rtl/fft32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft32_seq_ctrl
//
// Sequencer for a 32-point constant-geometry DIF FFT that reuses a single
// butterfly_32 (16 radix-2 butterflies) for all five stages. It holds no
// sample data. It generates the load handshake and write addresses, the
// per-stage operand capture and writeback strobes, the sixteen twiddle
// exponents, and the bit-reversed read addresses for unload.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a transform (sampled only when idle)
//   in_valid     input sample present      / in_ready  controller accepts it
//   ld_we        buffer write strobe for a loaded sample (in_valid & in_ready)
//   ld_addr      natural-order load address
//   bf_en        capture all 32 buffer words into butterfly operand registers
//   stage        current stage 0..4
//   tw_exp       16 x 4-bit twiddle exponents, [4k+3:4k] feeds butterfly k
//   wb_we        write butterfly results back with perfect shuffle
//   out_valid    output sample present     / out_ready downstream accepts it
//   rd_addr      buffer read address of current output, bitrev5(out_cnt)
//   busy         high whenever a transform is in progress
//   done         one-cycle pulse after the last output is accepted
// -----------------------------------------------------------------------------
module fft32_seq_ctrl #(
    parameter int NPT    = 32,
    parameter int STAGES = 5,
    parameter int BF_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ld_we,
    output logic [4:0]  ld_addr,
    output logic        bf_en,
    output logic [2:0]  stage,
    output logic [63:0] tw_exp,
    output logic        wb_we,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  rd_addr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_UNLOAD
    } state_t;

    localparam logic [4:0] LAST_IDX   = 5'(NPT - 1);
    localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);
    // Last WAIT count; only meaningful when BF_LAT > 1 (WAIT is skipped otherwise).
    localparam logic [2:0] WAIT_LAST  = 3'(BF_LAT - 2);

    function automatic logic [4:0] bitrev5(input logic [4:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    // Butterfly k in stage s uses exponent k with its low s bits cleared.
    function automatic logic [63:0] twiddles(input logic [2:0] s);
        logic [63:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            t[4*k +: 4] = 4'((k >> s) << s);
        end
        return t;
    endfunction

    state_t      state_q,     state_d;
    logic [4:0]  ld_addr_q,   ld_addr_d;
    logic [4:0]  out_cnt_q,   out_cnt_d;
    logic [2:0]  wait_cnt_q,  wait_cnt_d;
    logic [2:0]  stage_q,     stage_d;
    logic        in_ready_q,  in_ready_d;
    logic        bf_en_q,     bf_en_d;
    logic        wb_we_q,     wb_we_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [4:0]  rd_addr_q,   rd_addr_d;
    logic [63:0] tw_exp_q,    tw_exp_d;

    // Load strobe is combinational so a sample is written in the cycle it is accepted.
    assign ld_we = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        ld_addr_d  = ld_addr_q;
        out_cnt_d  = out_cnt_q;
        wait_cnt_d = wait_cnt_q;
        stage_d    = stage_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (ld_we) begin
                    if (ld_addr_q == LAST_IDX) begin
                        ld_addr_d = '0;
                        state_d   = S_ISSUE;
                    end else begin
                        ld_addr_d = ld_addr_q + 5'd1;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = (BF_LAT == 1) ? S_WB : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = S_WB;
                else                         wait_cnt_d = wait_cnt_q + 3'd1;
            end
            S_WB: begin
                if (stage_q == LAST_STAGE) begin
                    state_d = S_UNLOAD;
                end else begin
                    stage_d = stage_q + 3'd1;
                    state_d = S_ISSUE;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (out_cnt_q == LAST_IDX) begin
                        out_cnt_d = '0;
                        stage_d   = '0;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet
        // aligned with the state they describe.
        in_ready_d  = (state_d == S_LOAD);
        bf_en_d     = (state_d == S_ISSUE);
        wb_we_d     = (state_d == S_WB);
        out_valid_d = (state_d == S_UNLOAD);
        busy_d      = (state_d != S_IDLE);
        rd_addr_d   = out_valid_d ? bitrev5(out_cnt_d) : 5'd0;
        tw_exp_d    = busy_d ? twiddles(stage_d) : 64'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ld_addr_q   <= '0;
            out_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            stage_q     <= '0;
            in_ready_q  <= 1'b0;
            bf_en_q     <= 1'b0;
            wb_we_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_addr_q   <= '0;
            tw_exp_q    <= '0;
        end else begin
            state_q     <= state_d;
            ld_addr_q   <= ld_addr_d;
            out_cnt_q   <= out_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            bf_en_q     <= bf_en_d;
            wb_we_q     <= wb_we_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_addr_q   <= rd_addr_d;
            tw_exp_q    <= tw_exp_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign ld_addr   = ld_addr_q;
    assign bf_en     = bf_en_q;
    assign stage     = stage_q;
    assign tw_exp    = tw_exp_q;
    assign wb_we     = wb_we_q;
    assign out_valid = out_valid_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
